seq_mul_div: RTL and testbench

- Parametrised sequential arithmetic unit. Performs N-bit unsigned or signed multiplication, and division when compiled in.
- Operands, mode and results move over one shared bidirectional N-bit data bus, steered by a func code and an output enable.
- Successor to the fixed unsigned shift-add multiplier. Adds signed mode, a readable 2N-bit result (LO/HI halves), a status word and start edge detection.

---
 rtl/seq_mul_div_pkg.sv | 35 +++
 rtl/seq_mul_div_core.sv | 188 ++++++++++++++++++
 rtl/seq_mul_div.sv | 122 ++++++++++++
 tb/tb_seq_mul_div.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_div_pkg
// Description : Shared types and bit indices for the seq_mul_div unit:
//               bus function codes, FSM states, mode and status bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mul_div_pkg;

    // Bus operation codes carried on func[2:0]
    typedef enum logic [2:0] {
        FUNC_LOAD_A      = 3'b000,
        FUNC_LOAD_B      = 3'b001,
        FUNC_READ_LO     = 3'b010,
        FUNC_READ_HI     = 3'b011,
        FUNC_SET_MODE    = 3'b100,
        FUNC_READ_STATUS = 3'b101,
        FUNC_RESERVED    = 3'b110,
        FUNC_RUN         = 3'b111
    } func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2
    } state_t;

    localparam int MODE_SIGNED  = 0;
    localparam int MODE_DIV     = 1;

    localparam int STATUS_READY = 0;
    localparam int STATUS_DZ    = 1;

endpackage
`default_nettype wire

// File: rtl/seq_mul_div_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_div_core
// Description : N-step sequential datapath. Shift-add multiply on operand
//               magnitudes (and restoring divide when SEQ_MUL_DIV_DIVIDE_EN is
//               defined), followed by one ADJ cycle that applies the result
//               sign. Operands are snapshotted on launch.
// Ports       : clock, reset  - clock / synchronous active-high reset
//               launch        - one-cycle request, honoured only when idle
//               a, b, sgn     - operands and signed-mode flag
//               div           - divide select (macro builds only)
//               busy          - high from the launch edge until ADJ completes
//               lo, hi        - result halves (product, or quotient/remainder)
//               dz            - divide-by-zero flag (macro builds only)
// Macro       : SEQ_MUL_DIV_DIVIDE_EN adds the divide datapath and dz.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_div_core
    import seq_mul_div_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         launch,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sgn,
`ifdef SEQ_MUL_DIV_DIVIDE_EN
    input  logic         div,
    output logic         dz,
`endif
    output logic         busy,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  magb_q, magb_d;   // multiplicand / divisor magnitude
    logic          neg_q, neg_d;     // operand signs differ in signed mode

    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic [N:0]    mul_sum;
    logic [2*N-1:0] prod_neg;

    // Two's complement negation of the most negative value yields the same
    // bit pattern, which read as unsigned is exactly its magnitude.
    assign mag_a    = (sgn && a[N-1]) ? -a : a;
    assign mag_b    = (sgn && b[N-1]) ? -b : b;
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, magb_q} : {(N+1){1'b0}});
    assign prod_neg = -{hi_q, lo_q};

`ifdef SEQ_MUL_DIV_DIVIDE_EN
    logic          div_q, div_d;
    logic          dz_q, dz_d;
    logic [N-1:0]  araw_q, araw_d;   // raw dividend, returned as HI on B=0
    logic          nega_q, nega_d;   // dividend negative: remainder sign

    logic [N:0]    rshift;
    logic          ge;
    logic [N-1:0]  diff;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  quo_next;

    // Restoring step: remainder and quotient/dividend shift left together;
    // the trial subtraction fits in N bits whenever it succeeds.
    assign rshift   = {hi_q, lo_q[N-1]};
    assign ge       = (rshift >= {1'b0, magb_q});
    assign diff     = rshift[N-1:0] - magb_q;
    assign rem_next = ge ? diff : rshift[N-1:0];
    assign quo_next = {lo_q[N-2:0], ge};
    assign dz       = dz_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        magb_d  = magb_q;
        neg_d   = neg_q;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
        div_d   = div_q;
        dz_d    = dz_q;
        araw_d  = araw_q;
        nega_d  = nega_q;
`endif
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = CALC;
                    cnt_d   = CW'(N - 1);
                    lo_d    = mag_a;
                    hi_d    = '0;
                    magb_d  = mag_b;
                    neg_d   = sgn & (a[N-1] ^ b[N-1]);
`ifdef SEQ_MUL_DIV_DIVIDE_EN
                    div_d   = div;
                    dz_d    = div & (b == '0);
                    araw_d  = a;
                    nega_d  = sgn & a[N-1];
`endif
                end
            end
            CALC: begin
`ifdef SEQ_MUL_DIV_DIVIDE_EN
                if (div_q) begin
                    hi_d = rem_next;
                    lo_d = quo_next;
                end else
`endif
                begin
                    {hi_d, lo_d} = {mul_sum, lo_q[N-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = ADJ;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ADJ: begin
                state_d = IDLE;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
                if (div_q) begin
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = araw_q;
                    end else begin
                        if (neg_q) begin
                            lo_d = -lo_q;
                        end
                        if (nega_q) begin
                            hi_d = -hi_q;
                        end
                    end
                end else
`endif
                begin
                    if (neg_q) begin
                        {hi_d, lo_d} = prod_neg;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            magb_q  <= '0;
            neg_q   <= 1'b0;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            araw_q  <= '0;
            nega_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            magb_q  <= magb_d;
            neg_q   <= neg_d;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
            div_q   <= div_d;
            dz_q    <= dz_d;
            araw_q  <= araw_d;
            nega_q  <= nega_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule
`default_nettype wire

// File: rtl/seq_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_div
// Description : Sequential multiply (and optional divide) unit behind a shared
//               tristate bus. Holds operand/mode registers, start edge detect,
//               bus decode and the read mux; arithmetic lives in the core.
// Ports       : clock, reset - clock / synchronous active-high reset
//               start        - run request, acted on at its rising edge
//               func[2:0]    - bus operation code
//               oe           - output enable for the read codes
//               data[N-1:0]  - bidirectional operand/result bus
//               ready        - idle, result valid, loads accepted
//               dz           - divide-by-zero flag of the last operation
// Macro       : SEQ_MUL_DIV_DIVIDE_EN enables divide mode and dz.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_div
    import seq_mul_div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   func,
    input  logic         oe,
    inout  wire  [N-1:0] data,
    output logic         ready,
    output logic         dz
);

    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [1:0]   mode_q, mode_d;
    logic         start_q;

    logic         launch;
    logic         busy;
    logic [N-1:0] core_lo;
    logic [N-1:0] core_hi;
    logic [3:0]   status4;
    logic [N-1:0] rd_data;
    logic         drive;

    assign ready  = ~busy;
    assign launch = start & ~start_q & (func == FUNC_RUN) & ready;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        if (ready) begin
            case (func_t'(func))
                FUNC_LOAD_A:   a_d = data;
                FUNC_LOAD_B:   b_d = data;
                FUNC_SET_MODE: begin
                    mode_d[MODE_SIGNED] = data[MODE_SIGNED];
`ifdef SEQ_MUL_DIV_DIVIDE_EN
                    mode_d[MODE_DIV]    = data[MODE_DIV];
`else
                    mode_d[MODE_DIV]    = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            start_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            start_q <= start;
        end
    end

    seq_mul_div_core #(
        .N (N)
    ) u_core (
        .clock  (clock),
        .reset  (reset),
        .launch (launch),
        .a      (a_q),
        .b      (b_q),
        .sgn    (mode_q[MODE_SIGNED]),
`ifdef SEQ_MUL_DIV_DIVIDE_EN
        .div    (mode_q[MODE_DIV]),
        .dz     (dz),
`endif
        .busy   (busy),
        .lo     (core_lo),
        .hi     (core_hi)
    );

`ifndef SEQ_MUL_DIV_DIVIDE_EN
    assign dz = 1'b0;
`endif

    // Status word {mode[1:0], dz, ready}; fitted to the bus width.
    assign status4 = {mode_q, dz, ready};

    always_comb begin
        rd_data = '0;
        drive   = 1'b0;
        case (func_t'(func))
            FUNC_READ_LO:     begin rd_data = core_lo;     drive = oe; end
            FUNC_READ_HI:     begin rd_data = core_hi;     drive = oe; end
            FUNC_READ_STATUS: begin rd_data = N'(status4); drive = oe; end
            default: ;
        endcase
    end

    assign data = drive ? rd_data : {N{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mul_div
// Description : Self-checking bench for seq_mul_div (N=8). A behavioural model
//               computes results with plain integer arithmetic; a per-cycle
//               monitor compares ready/dz, and reads are compared on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mul_div;
    import seq_mul_div_pkg::*;

    localparam int N = 8;
`ifdef SEQ_MUL_DIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   func;
    logic         oe;
    logic [N-1:0] tb_d;
    logic         tb_en;
    wire  [N-1:0] data;
    logic         ready;
    logic         dz;

    assign data = tb_en ? tb_d : {N{1'bz}};

    always #5 clock = ~clock;

    seq_mul_div #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .func  (func),
        .oe    (oe),
        .data  (data),
        .ready (ready),
        .dz    (dz)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_a = '0, m_b = '0, m_lo = '0, m_hi = '0;
    logic [1:0]   m_mode = '0;
    logic         m_dz = 1'b0, m_prev = 1'b0;
    int           m_busy = 0;

    function automatic void calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [1:0] mode,
                                 output logic [N-1:0] lo, output logic [N-1:0] hi,
                                 output logic z);
        longint sa, sb, p, q, r;
        sa = mode[0] ? longint'($signed(a)) : longint'(a);
        sb = mode[0] ? longint'($signed(b)) : longint'(b);
        z  = 1'b0;
        if (mode[1]) begin
            if (b == '0) begin
                z  = 1'b1;
                lo = '1;
                hi = a;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                lo = q[N-1:0];
                hi = r[N-1:0];
            end
        end else begin
            p  = sa * sb;
            lo = p[N-1:0];
            hi = p[2*N-1:N];
        end
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_a = '0; m_b = '0; m_lo = '0; m_hi = '0;
            m_mode = '0; m_dz = 1'b0; m_prev = 1'b0; m_busy = 0;
        end else begin
            if (m_busy > 0) begin
                m_busy--;
            end else begin
                case (func)
                    3'b000: m_a = data;
                    3'b001: m_b = data;
                    3'b100: m_mode = {DIV_EN & data[1], data[0]};
                    default: ;
                endcase
                if (func == 3'b111 && start && !m_prev) begin
                    calc(m_a, m_b, m_mode, m_lo, m_hi, m_dz);
                    m_busy = N + 1;
                end
            end
            m_prev = start;
        end
    end

    // Per-cycle compare of ready, and of dz whenever the unit is idle
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("ready", ready, (m_busy == 0));
            if (m_busy == 0) check("dz", dz, m_dz);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [2:0] f, input logic [N-1:0] v);
        func = f; tb_en = 1'b1; tb_d = v;
        tick();
        tb_en = 1'b0; func = FUNC_RESERVED;
    endtask

    task automatic rd(input logic [2:0] f, output logic [N-1:0] v);
        func = f; oe = 1'b1;
        #1;
        v = data;
        oe = 1'b0; func = FUNC_RESERVED;
        tick();
    endtask

    task automatic run_op(input int hold, input bit midload, output int cyc);
        int k;
        func = FUNC_RUN; start = 1'b1;
        tick();
        cyc = 0;
        k = 1;
        while (!ready && cyc < 100) begin
            cyc++;
            if (k == hold) start = 1'b0;
            if (midload && cyc == 4) begin
                func = FUNC_LOAD_A; tb_en = 1'b1; tb_d = 8'h11;
            end
            if (midload && cyc == 5) begin
                tb_en = 1'b0; func = FUNC_RUN;
            end
            k++;
            tick();
        end
        start = 1'b0; func = FUNC_RESERVED; tb_en = 1'b0;
        if (cyc >= 100) $display("FAIL run_timeout: got busy after %0d cycles, expected 0x%0h", cyc, N + 1);
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] v;
        rd(FUNC_READ_LO, v);     check({tag, "_lo"}, v, m_lo);
        rd(FUNC_READ_HI, v);     check({tag, "_hi"}, v, m_hi);
        rd(FUNC_READ_STATUS, v); check({tag, "_status"}, v, {4'b0, m_mode, m_dz, 1'b1});
    endtask

    task automatic expect_lit(input string tag, input logic [N-1:0] lo, input logic [N-1:0] hi);
        logic [N-1:0] v;
        rd(FUNC_READ_LO, v); check({tag, "_lo_lit"}, v, lo);
        rd(FUNC_READ_HI, v); check({tag, "_hi_lit"}, v, hi);
    endtask

    task automatic setup(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] mode);
        load(FUNC_LOAD_A, a);
        load(FUNC_LOAD_B, b);
        load(FUNC_SET_MODE, {6'b0, mode});
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h80;
            3: return 8'hFF;
            4: return 8'h7F;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] v;
        int cyc;
        reset = 1'b1; start = 1'b0; func = FUNC_RESERVED; oe = 1'b0;
        tb_en = 1'b0; tb_d = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("reset_ready", ready, 1'b1);
        check("reset_dz", dz, 1'b0);
        rd(FUNC_READ_STATUS, v); check("reset_status", v, 8'h01);
        rd(FUNC_READ_LO, v);     check("reset_lo", v, 8'h00);
        rd(FUNC_READ_HI, v);     check("reset_hi", v, 8'h00);

        // Unsigned multiply 123*234
        setup(8'd123, 8'd234, 2'b00);
        run_op(1, 1'b0, cyc);
        check("umul_latency", cyc, N + 1);
        expect_lit("umul", 8'h6E, 8'h70);
        check_model("umul");

        // Bus release: the bench's own value must appear unaltered
        func = FUNC_READ_LO; oe = 1'b0; tb_en = 1'b1;
        tb_d = 8'h00; #1; check("bus_oe0_00", data, 8'h00);
        tb_d = 8'hFF; #1; check("bus_oe0_ff", data, 8'hFF);
        func = FUNC_LOAD_A; oe = 1'b1;
        tb_d = 8'h00; #1; check("bus_loada_00", data, 8'h00);
        tb_d = 8'hFF; #1; check("bus_loada_ff", data, 8'hFF);
        func = FUNC_RUN;
        tb_d = 8'h00; #1; check("bus_run_00", data, 8'h00);
        tb_d = 8'hFF; #1; check("bus_run_ff", data, 8'hFF);
        func = FUNC_RESERVED; oe = 1'b0; tb_en = 1'b0;
        tick();

        // Signed and unsigned multiply of 0x55 by 0xAA
        setup(8'h55, 8'hAA, 2'b01);
        run_op(1, 1'b0, cyc);
        check("smul_latency", cyc, N + 1);
        expect_lit("smul", 8'h72, 8'hE3);
        check_model("smul");
        load(FUNC_SET_MODE, 8'h00);
        run_op(1, 1'b0, cyc);
        expect_lit("umul2", 8'h72, 8'h38);

        // Held start plus a load while busy: one operation, A untouched
        load(FUNC_SET_MODE, 8'h01);
        run_op(3, 1'b1, cyc);
        check("hold_latency", cyc, N + 1);
        repeat (4) tick();
        expect_lit("hold", 8'h72, 8'hE3);
        run_op(1, 1'b0, cyc);
        expect_lit("rerun", 8'h72, 8'hE3);
        check_model("rerun");

`ifdef SEQ_MUL_DIV_DIVIDE_EN
        setup(8'd234, 8'd7, 2'b10);
        run_op(1, 1'b0, cyc);
        check("udiv_latency", cyc, N + 1);
        expect_lit("udiv", 8'h21, 8'h03);
        setup(8'h9C, 8'd7, 2'b11);
        run_op(1, 1'b0, cyc);
        expect_lit("sdiv", 8'hF2, 8'hFE);
        check_model("sdiv");
        setup(8'h5B, 8'h00, 2'b10);
        run_op(1, 1'b0, cyc);
        check("dz_latency", cyc, N + 1);
        check("dz_flag", dz, 1'b1);
        expect_lit("divz", 8'hFF, 8'h5B);
        rd(FUNC_READ_STATUS, v); check("divz_status", v, 8'h0B);
        setup(8'h80, 8'hFF, 2'b11);
        run_op(1, 1'b0, cyc);
        check("wrap_dz", dz, 1'b0);
        expect_lit("wrap", 8'h80, 8'h00);
`else
        load(FUNC_SET_MODE, 8'h03);
        rd(FUNC_READ_STATUS, v); check("mode_nodiv_status", v, 8'h05);
        setup(8'd234, 8'd7, 2'b10);
        run_op(1, 1'b0, cyc);
        expect_lit("nodiv_mul", 8'h66, 8'h06);
`endif

        // Reset during the fourth CALC cycle
        setup(8'd200, 8'd201, 2'b00);
        func = FUNC_RUN; start = 1'b1;
        tick();
        start = 1'b0; func = FUNC_RESERVED;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_ready", ready, 1'b1);
        expect_lit("rst_mid", 8'h00, 8'h00);
        rd(FUNC_READ_STATUS, v); check("rst_mid_status", v, 8'h01);

        // Randomised operations against the model
        for (int i = 0; i < 40; i++) begin
            setup(pick(), pick(), 2'($urandom_range(0, 3)));
            run_op(int'($urandom_range(1, 3)), 1'b0, cyc);
            check("rand_latency", cyc, N + 1);
            check_model("rand");
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
